// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types, constants and helpers for the nibble add/sub sequencer
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   NIBBLE_W   : width of one adder slice
//   sat_value  : signed saturation pattern for a given sign and width
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Positive overflow (sign=0) saturates to 0x7F..F, negative to 0x80..0.
  // Bits at and above 'width' are zero.
  function automatic logic [63:0] sat_value(input logic sign, input int width);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < width - 1) begin
        v[i] = ~sign;
      end else if (i == width - 1) begin
        v[i] = sign;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/nibble_addsub.sv
// rtl/nibble_addsub.sv - combinational 4-bit adder-subtractor slice
//   a, b : operand nibbles
//   m    : 0 = add, 1 = subtract (b is inverted internally)
//   cin  : carry in, driven by the sequencer's carry chain
//   sum  : result nibble
//   cout : carry out
module nibble_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] b_x;

  // The +1 of two's complement is not added here; it arrives through cin.
  assign b_x         = b ^ {4{m}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {4'b0000, cin};

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// rtl/addsub_nibble_sequencer.sv - wide add/sub serialised through one 4-bit slice, LSB nibble first
//   Optional macro: ADDSUB_SAT_EN (saturate out_result on signed overflow)
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_sub    : operands and op (0 = A+B, 1 = A-B)
//   out_valid/out_ready   : result handshake
//   out_result            : W-bit result
//   out_carry/ovf/zero    : final carry (1 = no borrow on subtract), signed overflow, zero flag
//   busy                  : FSM not in IDLE
module addsub_nibble_sequencer
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    in_a,
  input  logic [4*NIBBLES-1:0]    in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    out_result,
  output logic                    out_carry,
  output logic                    out_ovf,
  output logic                    out_zero,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  state_t                  state_q;
  logic [W-1:0]            a_q;
  logic [W-1:0]            b_q;
  logic                    op_q;
  logic                    carry_q;
  // Holds the nibbles already produced; the current sum is prepended on top.
  logic [W-NIBBLE_W-1:0]   res_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic [W-1:0]            out_result_q;
  logic                    out_carry_q;
  logic                    out_ovf_q;
  logic                    out_zero_q;

  logic [NIBBLE_W-1:0]     sum;
  logic                    cout;
  logic                    last;
  logic [W-1:0]            res_d;
  logic                    ovf_d;
  logic [W-1:0]            final_d;
  logic                    zero_d;

  nibble_addsub u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .m    (op_q),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  assign last  = (idx_q == IDX_W'(NIBBLES - 1));
  assign res_d = {sum, res_q};
  // Only meaningful on the last nibble, where a_q/b_q hold the sign nibbles.
  assign ovf_d = (a_q[NIBBLE_W-1] == (b_q[NIBBLE_W-1] ^ op_q)) &&
                 (sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);

`ifdef ADDSUB_SAT_EN
  logic [63:0] sat_full;
  assign sat_full = sat_value(a_q[NIBBLE_W-1], W);
  assign final_d  = ovf_d ? sat_full[W-1:0] : res_d;
`else
  assign final_d  = res_d;
`endif

  assign zero_d = (final_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      carry_q      <= 1'b0;
      res_q        <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= in_sub;
            carry_q    <= in_sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d[W-1:NIBBLE_W];
          carry_q <= cout;
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          if (last) begin
            out_result_q <= final_d;
            out_carry_q  <= cout;
            out_ovf_q    <= ovf_d;
            out_zero_q   <= zero_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_ovf    = out_ovf_q;
  assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// tb/tb_addsub_nibble_sequencer.sv - directed self-checking bench for addsub_nibble_sequencer
module tb_addsub_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, check result/flags, then drain.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_res, input logic exp_c,
                        input logic exp_v, input logic exp_z, input bit drain);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    check({tag, "_result"},  32'(out_result), 32'(exp_res));
    check({tag, "_carry"},   32'(out_carry), 32'(exp_c));
    check({tag, "_ovf"},     32'(out_ovf), 32'(exp_v));
    check({tag, "_zero"},    32'(out_zero), 32'(exp_z));
    if (drain) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  logic [W-1:0] exp_sat_pos;
  logic [W-1:0] exp_sat_neg;

  initial begin
    int quiet;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
`ifdef ADDSUB_SAT_EN
    exp_sat_pos = 16'h7FFF;
    exp_sat_neg = 16'h8000;
`else
    exp_sat_pos = 16'h8000;
    exp_sat_neg = 16'h7FFF;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_result",    32'(out_result), 32'd0);
    check("rst_flags",     {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_zero",  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, exp_sat_pos, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0003, 16'h0004, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, exp_sat_neg, 1'b1, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held while new requests are presented and ignored.
    run_op("bp", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid",  32'(out_valid), 32'd1);
      check("bp_hold_result", 32'(out_result), 32'h0100);
      check("bp_hold_flags",  {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
      check("bp_in_ready",    32'(in_ready), 32'd0);
      check("bp_busy",        32'(busy), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    run_op("bp_next", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while processing nibble 2.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h4321;
    in_b     = 16'h1111;
    in_sub   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready",  32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy",      32'(busy), 32'd0);
    check("mrst_result",    32'(out_result), 32'd0);
    check("mrst_flags",     {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) quiet++;
    end
    check("mrst_no_valid", 32'(quiet), 32'd0);
    check("mrst_ready",    32'(in_ready), 32'd1);
    run_op("post_rst", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
